uart_transmitter_bit: RTL and testbench
=======================================

Name: uart_transmitter_bit

Overview:
- Bit-level UART transmitter, the transmit-side counterpart of the bit-level receiver.
- Accepts a single-bit stream through a valid/ready handshake and packs 8 bits LSB-first into a byte.
- Double-buffers the packed byte and serialises it as an 8N1 frame on tx, clocked by the shared 16x-oversampled baud_tick from the baud ticker.
- Sits between bit-producing logic (e.g. cipher output) and the UART tx pin.

Parameters:
- OVERSAMPLE, 16, baud_tick pulses per serial bit; legal range 2..255.
- STOP_BITS, 1, stop bits per frame; legal values 1 or 2.

Ports:
- clk  input  1  system clock; all logic on rising edge.
- rst  input  1  asynchronous, active-low reset.
- baud_tick  input  1  single-cycle pulse at OVERSAMPLE x baud rate.
- bit_in  input  1  data bit to transmit.
- bit_valid  input  1  bit_in is valid this cycle.
- bit_ready  output  1  block can accept a bit this cycle.
- flush  input  1  single-cycle request to send a partially packed byte.
- tx  output  1  serial line; idles high.
- busy  output  1  frame in progress, or a byte waiting in the hold register.
- pack_count  output  4  bits currently in the packer, 0..8.

Behaviour:
- Reset (rst low, asynchronous):
  - tx=1, bit_ready=1, busy=0, pack_count=0.
  - Hold register empty; FSM in IDLE; tick and bit counters cleared.
  - A frame in flight is abandoned immediately: tx returns high and no partial frame resumes after release.
- Packer:
  - A bit is accepted on a cycle where bit_valid && bit_ready.
  - The bit is stored at position pack_count (LSB first), then pack_count increments.
  - pack_count==8 marks the packer full. On the next edge the byte moves to the hold register if the hold register is empty, and pack_count returns to 0.
  - bit_ready = !(pack_count==8).
  - Sustained rate: one bit per clk, except one stall cycle per byte. Beyond that, the packer stalls only when the hold register is also occupied.
- Flush:
  - If flush=1 and 0<pack_count<8, the remaining upper bits are zero-padded and pack_count is forced to 8.
  - Flush with pack_count==0 or ==8 is ignored.
  - Flush and an accepted bit in the same cycle: the bit is stored first, then padding is applied (if the result is 8, flush has no further effect).
- Hold register: one byte plus a valid flag. It is loaded from the packer and cleared when the FSM copies it into the shift register.
- FSM states IDLE, START, DATA, PARITY (optional feature only), STOP.
  - IDLE: tx=1. When hold is valid, go to START on the next edge, load the shift register, clear the tick counter and the hold flag.
  - START: tx=0 for OVERSAMPLE baud_ticks, then go to DATA with bit index 0.
  - DATA: tx=shift[0] for OVERSAMPLE ticks per bit. Shift right after each bit; after bit index 7 go to PARITY or STOP.
  - PARITY: tx=parity bit for OVERSAMPLE ticks, then go to STOP.
  - STOP: tx=1 for STOP_BITS x OVERSAMPLE ticks, then go to IDLE.
  - If hold is valid on exit from STOP, IDLE lasts exactly one clk before the next START. There is no extra idle bit time.
- Tick counter:
  - Width is ceil(log2(OVERSAMPLE)).
  - Advances only on baud_tick and wraps at OVERSAMPLE-1.
  - State changes happen on the clk edge that consumes the terminal tick.
- Timing:
  - busy = (state != IDLE) || hold_valid.
  - tx is registered, with no glitches.
  - Latency from accepting the 8th bit to tx falling: 2 clk when the FSM is idle.
- baud_tick held high continuously is legal in simulation: each clk counts as one tick.

Optional Feature:
- Macro: UART_TX_BIT_PARITY_EN.
- Defined: the PARITY state is inserted after DATA and transmits even parity, i.e. the XOR of the 8 data bits. The frame becomes 8E1, or 8E2 with STOP_BITS=2.
- Undefined: the PARITY state, its logic and its encoding are absent; the frame is 8N1/8N2.

Test Plan:
- Reset, then feed bits 1,0,1,0,0,1,0,1 (byte 0xA5), baud_tick every clk, OVERSAMPLE=16 -> tx low for 16 clk, then data 1,0,1,0,0,1,0,1 for 16 clk each, high stop for 16 clk; busy falls after the stop bit.
- Stream 24 bits (0x3C, 0xFF, 0x00) with bit_valid held high -> three back-to-back frames with one idle clk between stop and start. bit_ready stalls only when pack and hold are both full. Bit order is preserved.
- Feed 3 bits 1,1,1 then pulse flush -> one frame with data byte 0x07; pack_count returns to 0.
- Flush with pack_count==0 -> no frame, tx stays high, busy stays 0. Flush in the same cycle as the 8th bit -> exactly one frame.
- Assert rst low mid-DATA of 0xA5 -> tx=1 asynchronously, busy=0, pack_count=0. After release, tx stays idle until new bits arrive.
- With UART_TX_BIT_PARITY_EN defined, send 0xA5 then 0x07 -> parity bit 0 for 0xA5 and 1 for 0x07, each lasting 16 ticks between data bit 7 and stop.

Source files
------------

// File: rtl/uart_transmitter_bit.sv
// uart_transmitter_bit: packs a valid/ready bit stream LSB-first into bytes, double-buffers them
// and serialises 8N1/8N2 frames on tx. Defining UART_TX_BIT_PARITY_EN inserts an even parity bit.
module uart_transmitter_bit #(
  parameter int OVERSAMPLE = 16,
  parameter int STOP_BITS  = 1
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       baud_tick,
  input  logic       bit_in,
  input  logic       bit_valid,
  output logic       bit_ready,
  input  logic       flush,
  output logic       tx,
  output logic       busy,
  output logic [3:0] pack_count
);

  localparam int            TW        = $clog2(OVERSAMPLE);
  localparam logic [TW-1:0] TICK_LAST = TW'(OVERSAMPLE - 32'sd1);
  localparam logic          STOP_LAST = 1'(STOP_BITS - 32'sd1);

`ifdef UART_TX_BIT_PARITY_EN
  typedef enum logic [2:0] {
    IDLE   = 3'd0,
    START  = 3'd1,
    DATA   = 3'd2,
    PARITY = 3'd3,
    STOP   = 3'd4
  } state_t;
`else
  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    START = 2'd1,
    DATA  = 2'd2,
    STOP  = 2'd3
  } state_t;
`endif

  function automatic logic even_parity(input logic [7:0] data);
    return ^data;
  endfunction

  state_t        state_r;
  logic [3:0]    pack_count_r;
  logic [7:0]    pack_data_r;
  logic          hold_valid_r;
  logic [7:0]    hold_data_r;
  logic [7:0]    shift_r;
  logic [TW-1:0] tick_r;
  logic [2:0]    bit_idx_r;
  logic          stop_idx_r;
  logic          tx_r;
`ifdef UART_TX_BIT_PARITY_EN
  logic          parity_r;
`endif

  logic          pack_full_s;
  logic          bit_ready_s;
  logic          accept_s;
  logic          move_s;
  logic          take_s;
  logic          last_tick_s;
  logic [3:0]    cnt_next_s;
  logic [7:0]    data_next_s;

  assign pack_full_s = (pack_count_r == 4'd8);
  assign bit_ready_s = !pack_full_s;
  assign accept_s    = bit_valid && bit_ready_s;
  assign move_s      = pack_full_s && !hold_valid_r;
  assign take_s      = (state_r == IDLE) && hold_valid_r;
  assign last_tick_s = baud_tick && (tick_r == TICK_LAST);

  // Packer next state: store the accepted bit first, then let flush pad up to a full byte.
  always_comb begin
    cnt_next_s  = pack_count_r;
    data_next_s = pack_data_r;
    if (move_s) begin
      // Clearing here makes flush padding zero without any extra masking.
      cnt_next_s  = 4'd0;
      data_next_s = 8'h00;
    end else if (pack_full_s) begin
      cnt_next_s  = pack_count_r;
    end else begin
      if (accept_s) begin
        data_next_s[pack_count_r[2:0]] = bit_in;
        cnt_next_s                     = pack_count_r + 4'd1;
      end else begin
        cnt_next_s = pack_count_r;
      end
      if (flush && (cnt_next_s != 4'd0) && (cnt_next_s != 4'd8)) begin
        cnt_next_s = 4'd8;
      end else begin
        cnt_next_s = cnt_next_s;
      end
    end
  end

  // Packer and hold register; the hold flag is set by the packer and cleared when the FSM takes it.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      pack_count_r <= 4'd0;
      pack_data_r  <= 8'h00;
      hold_valid_r <= 1'b0;
      hold_data_r  <= 8'h00;
    end else begin
      pack_count_r <= cnt_next_s;
      pack_data_r  <= data_next_s;
      if (move_s) begin
        hold_valid_r <= 1'b1;
        hold_data_r  <= pack_data_r;
      end else if (take_s) begin
        hold_valid_r <= 1'b0;
      end else begin
        hold_valid_r <= hold_valid_r;
      end
    end
  end

  // Frame FSM; tx is updated on the same edge as each state change so it never glitches.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_r    <= IDLE;
      shift_r    <= 8'h00;
      tick_r     <= '0;
      bit_idx_r  <= 3'd0;
      stop_idx_r <= 1'b0;
      tx_r       <= 1'b1;
`ifdef UART_TX_BIT_PARITY_EN
      parity_r   <= 1'b0;
`endif
    end else begin
      if ((state_r != IDLE) && baud_tick) begin
        tick_r <= last_tick_s ? '0 : (tick_r + TW'(1'b1));
      end
      case (state_r)
        IDLE: begin
          tx_r <= 1'b1;
          if (take_s) begin
            state_r    <= START;
            shift_r    <= hold_data_r;
            tick_r     <= '0;
            bit_idx_r  <= 3'd0;
            stop_idx_r <= 1'b0;
            tx_r       <= 1'b0;
`ifdef UART_TX_BIT_PARITY_EN
            parity_r   <= even_parity(hold_data_r);
`endif
          end
        end
        START: begin
          if (last_tick_s) begin
            state_r <= DATA;
            tx_r    <= shift_r[0];
          end
        end
        DATA: begin
          if (last_tick_s) begin
            if (bit_idx_r == 3'd7) begin
`ifdef UART_TX_BIT_PARITY_EN
              state_r <= PARITY;
              tx_r    <= parity_r;
`else
              state_r <= STOP;
              tx_r    <= 1'b1;
`endif
            end else begin
              shift_r   <= {1'b0, shift_r[7:1]};
              tx_r      <= shift_r[1];
              bit_idx_r <= bit_idx_r + 3'd1;
            end
          end
        end
`ifdef UART_TX_BIT_PARITY_EN
        PARITY: begin
          if (last_tick_s) begin
            state_r <= STOP;
            tx_r    <= 1'b1;
          end
        end
`endif
        STOP: begin
          tx_r <= 1'b1;
          if (last_tick_s) begin
            if (stop_idx_r == STOP_LAST) begin
              state_r <= IDLE;
            end else begin
              stop_idx_r <= 1'b1;
            end
          end
        end
        default: begin
          state_r <= IDLE;
          tx_r    <= 1'b1;
        end
      endcase
    end
  end

  assign bit_ready  = bit_ready_s;
  assign tx         = tx_r;
  assign busy       = (state_r != IDLE) || hold_valid_r;
  assign pack_count = pack_count_r;

endmodule

// File: tb/tb_uart_transmitter_bit.sv
// Directed bench for uart_transmitter_bit: vector table of packed bytes plus hand-written
// sequences for latency, back-to-back streaming, asynchronous reset and the parity option.
module tb_uart_transmitter_bit;

  localparam int OS = 16;
`ifdef UART_TX_BIT_PARITY_EN
  localparam int PB = 1;
`else
  localparam int PB = 0;
`endif
  localparam int FLEN = OS * (10 + PB);

  typedef struct {
    int          nbits;
    logic [31:0] bits;
    bit          flush_after;
    bit          flush_last;
    int          exp_frames;
    logic [7:0]  exp_byte;
  } vec_t;

  logic       clk = 1'b0;
  logic       rst = 1'b0;
  logic       baud_tick = 1'b1;
  logic       bit_in = 1'b0;
  logic       bit_valid = 1'b0;
  logic       flush = 1'b0;
  logic       bit_ready;
  logic       tx;
  logic       busy;
  logic [3:0] pack_count;

  int         total = 0;
  int         bad = 0;
  bit         rec_en = 1'b0;
  bit         trace[$];
  int         busy_cnt = 0;
  logic [7:0] dec_bytes[$];
  int         dec_gaps[$];
  bit         dec_pars[$];
  int         dec_err = 0;
  vec_t       vecs[7];

  always #5 clk = ~clk;

  uart_transmitter_bit #(.OVERSAMPLE(OS), .STOP_BITS(1)) dut (
    .clk(clk), .rst(rst), .baud_tick(baud_tick), .bit_in(bit_in), .bit_valid(bit_valid),
    .bit_ready(bit_ready), .flush(flush), .tx(tx), .busy(busy), .pack_count(pack_count)
  );

  always @(negedge clk) begin
    if (rec_en) begin
      trace.push_back(tx);
      if (busy) busy_cnt++;
    end
  end

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  task automatic fail_now(input string name);
    total++;
    bad++;
    $display("FAIL %s: bound expired", name);
  endtask

  // Splits the recorded tx trace into frames, checking every bit period is exactly OS samples.
  task automatic decode();
    int i;
    int last_end;
    dec_bytes.delete(); dec_gaps.delete(); dec_pars.delete();
    dec_err = 0; last_end = -1; i = 0;
    while (i < trace.size()) begin
      if (trace[i] == 1'b0) begin
        logic [7:0] b;
        bit p;
        if (i + FLEN > trace.size()) begin
          dec_err++;
          break;
        end
        b = 8'h00; p = 1'b0;
        for (int k = 0; k < OS; k++) if (trace[i+k] != 1'b0) dec_err++;
        for (int n = 0; n < 8; n++) begin
          b[n] = trace[i+OS*(n+1)];
          for (int k = 0; k < OS; k++) if (trace[i+OS*(n+1)+k] != b[n]) dec_err++;
        end
        if (PB == 1) begin
          p = trace[i+OS*9];
          for (int k = 0; k < OS; k++) if (trace[i+OS*9+k] != p) dec_err++;
        end
        for (int k = 0; k < OS; k++) if (trace[i+OS*(9+PB)+k] != 1'b1) dec_err++;
        if (last_end >= 0) dec_gaps.push_back(i - last_end);
        dec_bytes.push_back(b);
        dec_pars.push_back(p);
        i += FLEN;
        last_end = i;
      end else begin
        i++;
      end
    end
  endtask

  // Presents n bits LSB-first with bit_valid held high; returns the clk count it took.
  task automatic feed(input logic [31:0] bits, input int n, input bit fl_last, output int cycles);
    cycles = 0;
    for (int k = 0; k < n; k++) begin
      int guard = 0;
      bit_in = bits[k];
      bit_valid = 1'b1;
      flush = fl_last && (k == n - 1);
      while (!bit_ready && guard < 400) begin
        @(negedge clk);
        guard++;
        cycles++;
      end
      if (guard >= 400) fail_now("feed_ready");
      @(negedge clk);
      cycles++;
    end
    bit_valid = 1'b0;
    flush = 1'b0;
    bit_in = 1'b0;
  endtask

  task automatic wait_idle();
    int g = 0;
    repeat (2) @(negedge clk);
    while ((busy || pack_count != 4'd0) && g < 1000) begin
      @(negedge clk);
      g++;
    end
    if (g >= 1000) fail_now("wait_idle");
    repeat (4) @(negedge clk);
  endtask

  task automatic start_rec();
    trace.delete();
    busy_cnt = 0;
    rec_en = 1'b1;
  endtask

  initial begin
    #5ms;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1, "watchdog");
  end

  initial begin
    int cyc;
    int zeros;

    vecs[0] = '{8, 32'h3C, 1'b0, 1'b0, 1, 8'h3C};
    vecs[1] = '{3, 32'h07, 1'b1, 1'b0, 1, 8'h07};
    vecs[2] = '{0, 32'h00, 1'b1, 1'b0, 0, 8'h00};
    vecs[3] = '{8, 32'h5A, 1'b0, 1'b1, 1, 8'h5A};
    vecs[4] = '{5, 32'h15, 1'b1, 1'b0, 1, 8'h15};
    vecs[5] = '{1, 32'h01, 1'b0, 1'b1, 1, 8'h01};
    vecs[6] = '{7, 32'h7F, 1'b1, 1'b0, 1, 8'h7F};

    repeat (3) @(negedge clk);
    check("rst_tx", tx, 1);
    check("rst_ready", bit_ready, 1);
    check("rst_busy", busy, 0);
    check("rst_pack", pack_count, 0);
    rst = 1'b1;
    repeat (2) @(negedge clk);

    // 0xA5 with 2-clk latency from the 8th accepted bit to the start bit.
    start_rec();
    feed(32'hA5, 8, 1'b0, cyc);
    check("a5_full_pack", pack_count, 8);
    check("a5_full_ready", bit_ready, 0);
    check("a5_full_busy", busy, 0);
    check("a5_lat1_tx", tx, 1);
    @(negedge clk);
    check("a5_hold_pack", pack_count, 0);
    check("a5_hold_busy", busy, 1);
    check("a5_lat2_tx", tx, 1);
    @(negedge clk);
    check("a5_start_tx", tx, 0);
    wait_idle();
    rec_en = 1'b0;
    decode();
    check("a5_frames", dec_bytes.size(), 1);
    if (dec_bytes.size() > 0) check("a5_byte", dec_bytes[0], 8'hA5);
    check("a5_shape", dec_err, 0);
    check("a5_busy_len", busy_cnt, 161 + OS * PB);

    for (int v = 0; v < 7; v++) begin
      start_rec();
      feed(vecs[v].bits, vecs[v].nbits, vecs[v].flush_last, cyc);
      if (vecs[v].flush_after) begin
        flush = 1'b1;
        @(negedge clk);
        flush = 1'b0;
      end
      check($sformatf("vec%0d_pack", v), pack_count, (vecs[v].exp_frames > 0) ? 8 : 0);
      check($sformatf("vec%0d_busy0", v), busy, 0);
      wait_idle();
      rec_en = 1'b0;
      decode();
      check($sformatf("vec%0d_frames", v), dec_bytes.size(), vecs[v].exp_frames);
      if (vecs[v].exp_frames > 0 && dec_bytes.size() > 0)
        check($sformatf("vec%0d_byte", v), dec_bytes[0], vecs[v].exp_byte);
      check($sformatf("vec%0d_shape", v), dec_err, 0);
      check($sformatf("vec%0d_tx_idle", v), tx, 1);
    end

    // Three bytes streamed with bit_valid held high: one stall per byte, one idle clk between frames.
    start_rec();
    feed({8'h00, 8'h00, 8'hFF, 8'h3C}, 24, 1'b0, cyc);
    check("stream_feed_cycles", cyc, 26);
    wait_idle();
    rec_en = 1'b0;
    decode();
    check("stream_frames", dec_bytes.size(), 3);
    if (dec_bytes.size() == 3) begin
      check("stream_b0", dec_bytes[0], 8'h3C);
      check("stream_b1", dec_bytes[1], 8'hFF);
      check("stream_b2", dec_bytes[2], 8'h00);
    end
    if (dec_gaps.size() == 2) begin
      check("stream_gap0", dec_gaps[0], 1);
      check("stream_gap1", dec_gaps[1], 1);
    end
    check("stream_shape", dec_err, 0);

    // Asynchronous reset during data bit 1 (a zero) of 0xA5.
    feed(32'hA5, 8, 1'b0, cyc);
    repeat (40) @(negedge clk);
    check("pre_rst_tx", tx, 0);
    check("pre_rst_busy", busy, 1);
    #2 rst = 1'b0;
    #1;
    check("async_rst_tx", tx, 1);
    check("async_rst_busy", busy, 0);
    check("async_rst_pack", pack_count, 0);
    @(negedge clk);
    rst = 1'b1;
    start_rec();
    repeat (300) @(negedge clk);
    rec_en = 1'b0;
    zeros = 0;
    foreach (trace[i]) if (trace[i] == 1'b0) zeros++;
    check("post_rst_tx_idle", zeros, 0);
    check("post_rst_busy", busy_cnt, 0);
    start_rec();
    feed(32'h81, 8, 1'b0, cyc);
    wait_idle();
    rec_en = 1'b0;
    decode();
    check("post_rst_frames", dec_bytes.size(), 1);
    if (dec_bytes.size() > 0) check("post_rst_byte", dec_bytes[0], 8'h81);

`ifdef UART_TX_BIT_PARITY_EN
    start_rec();
    feed(32'hA5, 8, 1'b0, cyc);
    wait_idle();
    feed(32'h07, 3, 1'b0, cyc);
    flush = 1'b1;
    @(negedge clk);
    flush = 1'b0;
    wait_idle();
    rec_en = 1'b0;
    decode();
    check("par_frames", dec_bytes.size(), 2);
    if (dec_pars.size() == 2) begin
      check("par_a5", dec_pars[0], 0);
      check("par_07", dec_pars[1], 1);
    end
    check("par_shape", dec_err, 0);
`endif

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
